// File: rtl/counter_ctrl.sv
// counter_ctrl: push-button front end for the 4-bit up/down counter.
// Synchronises and debounces the up, down and load buttons. It turns presses
// into one-cycle en/load pulses and auto-repeats steps while a direction
// button is held.
module counter_ctrl #(
  parameter int DB_LIMIT      = 250000,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  parameter int CNT_W         = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_load,
  input  logic [3:0] sw_data,
  output logic       en,
  output logic       mode,
  output logic       load,
  output logic [3:0] data
);

  localparam int BTN_UP = 0;
  localparam int BTN_DN = 1;
  localparam int BTN_LD = 2;

  localparam logic [CNT_W-1:0] DB_MAX   = CNT_W'(DB_LIMIT - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_MAX  = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic [2:0]       raw;
  logic [2:0]       lvl;
  logic [2:0]       lvl_prev;
  logic [2:0]       rise;

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic             dir;
  logic             act_lvl;
  logic             opp_lvl;
  logic             abort;

  assign raw = {btn_load, btn_down, btn_up};

  // Per-button synchroniser and debouncer.
  for (genvar g = 0; g < 3; g++) begin : g_btn
    logic             sync_p0;
    logic             sync_p1;
    logic             db_lvl;
    logic [CNT_W-1:0] db_cnt;

    // Stage 0/1: two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync_p0 <= 1'b0;
        sync_p1 <= 1'b0;
      end else begin
        sync_p0 <= raw[g];
        sync_p1 <= sync_p0;
      end
    end

    // Stage 2: accept a new level only after DB_LIMIT consecutive differing cycles.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        db_cnt <= '0;
        db_lvl <= 1'b0;
      end else if (sync_p1 != db_lvl) begin
        if (db_cnt == DB_MAX) begin
          db_lvl <= sync_p1;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + CNT_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end

    assign lvl[g] = db_lvl;
  end

  // Previous debounced levels, used to find rising edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl_prev <= 3'b000;
    end else begin
      lvl_prev <= lvl;
    end
  end

  assign rise = lvl & ~lvl_prev;

  // A held step is cancelled when its own button drops or the opposite one is pressed.
  assign act_lvl = dir ? lvl[BTN_UP] : lvl[BTN_DN];
  assign opp_lvl = dir ? lvl[BTN_DN] : lvl[BTN_UP];
  assign abort   = !act_lvl || opp_lvl;

  // Stage 3: step/load FSM with registered pulse outputs; load wins over any step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      dir   <= 1'b1;
      en    <= 1'b0;
      mode  <= 1'b1;
      load  <= 1'b0;
      data  <= 4'h0;
    end else begin
      en   <= 1'b0;
      load <= 1'b0;
      if (rise[BTN_LD]) begin
        load  <= 1'b1;
        data  <= sw_data;
        state <= IDLE;
        timer <= '0;
      end else begin
        case (state)
          IDLE: begin
            timer <= '0;
            if (rise[BTN_UP] && !lvl[BTN_DN]) begin
              en    <= 1'b1;
              mode  <= 1'b1;
              dir   <= 1'b1;
              state <= HOLD;
            end else if (rise[BTN_DN] && !lvl[BTN_UP]) begin
              en    <= 1'b1;
              mode  <= 1'b0;
              dir   <= 1'b0;
              state <= HOLD;
            end
          end
          HOLD: begin
            if (abort) begin
              state <= IDLE;
              timer <= '0;
            end else if (timer == HOLD_MAX) begin
              en    <= 1'b1;
              mode  <= dir;
              timer <= '0;
              state <= REPEAT;
            end else begin
              timer <= timer + CNT_W'(1);
            end
          end
          REPEAT: begin
            if (abort) begin
              state <= IDLE;
              timer <= '0;
            end else if (timer == REP_MAX) begin
              en    <= 1'b1;
              mode  <= dir;
              timer <= '0;
            end else begin
              timer <= timer + CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            timer <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Testbench for counter_ctrl: vector table, directed corner sequences and
// random button activity checked against a timing-rule reference model.
module tb_counter_ctrl;

  localparam int DB_LIMIT = 4;
  localparam int HOLD     = 20;
  localparam int REP      = 8;

  logic       clk;
  logic       reset;
  logic       btn_up;
  logic       btn_down;
  logic       btn_load;
  logic [3:0] sw_data;
  logic       en;
  logic       mode;
  logic       load;
  logic [3:0] data;

  counter_ctrl #(
    .DB_LIMIT     (DB_LIMIT),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP),
    .CNT_W        (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_up  (btn_up),
    .btn_down(btn_down),
    .btn_load(btn_load),
    .sw_data (sw_data),
    .en      (en),
    .mode    (mode),
    .load    (load),
    .data    (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_en;
  int n_ld;
  int en_times[$];

  // Reference model state (index 0 up, 1 down, 2 load).
  int                  k;
  logic [2:0]          ms0, ms1, mdb, mdbp;
  logic [DB_LIMIT-1:0] win [3];
  logic                active, adir;
  int                  t0;
  logic                e_en, e_load, e_mode;
  logic [3:0]          e_data;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    k = 0; ms0 = 0; ms1 = 0; mdb = 0; mdbp = 0;
    for (int b = 0; b < 3; b++) win[b] = '0;
    active = 0; adir = 1; t0 = 0;
    e_en = 0; e_load = 0; e_mode = 1; e_data = 4'h0;
  endtask

  // One rising edge of the model. A level is accepted once the synchronised
  // pin has disagreed with it for the last DB_LIMIT samples. Steps fall at
  // press time, press+HOLD, then every REP cycles.
  task automatic model_edge(input logic [2:0] p, input logic [3:0] s, input logic r);
    logic [2:0] rs;
    int el;
    int ai, oi;
    if (r) begin
      model_reset();
      return;
    end
    k++;
    rs = mdb & ~mdbp;
    e_en = 0;
    e_load = 0;
    ai = adir ? 0 : 1;
    oi = adir ? 1 : 0;
    if (rs[2]) begin
      e_load = 1; e_data = s; active = 0;
    end else if (active) begin
      if (!mdb[ai] || mdb[oi]) active = 0;
      else begin
        el = k - t0;
        if (el == HOLD || (el > HOLD && (el - HOLD) % REP == 0)) begin
          e_en = 1; e_mode = adir;
        end
      end
    end else if (rs[0] && !mdb[1]) begin
      active = 1; adir = 1; t0 = k; e_en = 1; e_mode = 1;
    end else if (rs[1] && !mdb[0]) begin
      active = 1; adir = 0; t0 = k; e_en = 1; e_mode = 0;
    end
    mdbp = mdb;
    for (int b = 0; b < 3; b++) begin
      win[b] = {win[b][DB_LIMIT-2:0], ms1[b]};
      if (win[b] == (mdb[b] ? {DB_LIMIT{1'b0}} : {DB_LIMIT{1'b1}})) mdb[b] = ~mdb[b];
    end
    ms1 = ms0;
    ms0 = p;
  endtask

  task automatic tick();
    logic [2:0] p;
    logic [3:0] s;
    logic r;
    @(posedge clk);
    p = {btn_load, btn_down, btn_up};
    s = sw_data;
    r = reset;
    model_edge(p, s, r);
    cyc++;
    @(negedge clk);
    check("outputs", {25'd0, en, load, mode, data}, {25'd0, e_en, e_load, e_mode, e_data});
    check("en_load_excl", {31'd0, en & load}, 32'd0);
    if (en) begin
      en_times.push_back(cyc);
      n_en++;
    end
    if (load) n_ld++;
  endtask

  typedef struct {
    logic       up;
    logic       dn;
    logic       ld;
    logic [3:0] sw;
    int         ncyc;
    int         x_en;
    int         x_ld;
    logic       x_mode;
    logic [3:0] x_data;
  } vec_t;

  vec_t tbl [12];
  int   exp_off [6];

  initial begin
    int base, h, l;
    int rem [3];
    logic [2:0] pins;

    tbl[0]  = '{0, 0, 0, 4'h0, 10, 0, 0, 1'b1, 4'h0};
    tbl[1]  = '{1, 0, 0, 4'h0, 36, 3, 0, 1'b1, 4'h0};
    tbl[2]  = '{0, 0, 0, 4'h0, 12, 0, 0, 1'b1, 4'h0};
    tbl[3]  = '{0, 0, 1, 4'hA, 10, 0, 1, 1'b1, 4'hA};
    tbl[4]  = '{0, 0, 0, 4'h3, 10, 0, 0, 1'b1, 4'hA};
    tbl[5]  = '{0, 1, 0, 4'h3, 28, 2, 0, 1'b0, 4'hA};
    tbl[6]  = '{1, 1, 0, 4'h3, 12, 0, 0, 1'b0, 4'hA};
    tbl[7]  = '{0, 1, 0, 4'h3, 12, 0, 0, 1'b0, 4'hA};
    tbl[8]  = '{0, 0, 0, 4'h3, 12, 0, 0, 1'b0, 4'hA};
    tbl[9]  = '{1, 0, 1, 4'h5, 10, 0, 1, 1'b0, 4'h5};
    tbl[10] = '{1, 0, 1, 4'h9, 30, 0, 0, 1'b0, 4'h5};
    tbl[11] = '{0, 0, 0, 4'h9, 12, 0, 0, 1'b0, 4'h5};
    exp_off = '{7, 27, 35, 43, 51, 59};

    reset = 1'b1; btn_up = 0; btn_down = 0; btn_load = 0; sw_data = 4'h0;
    model_reset();
    repeat (3) tick();
    check("reset_state", {25'd0, en, load, mode, data}, 32'h10);
    reset = 1'b0;

    // Vector table: consecutive records form one continuous scenario.
    for (int i = 0; i < 12; i++) begin
      btn_up = tbl[i].up; btn_down = tbl[i].dn; btn_load = tbl[i].ld; sw_data = tbl[i].sw;
      n_en = 0; n_ld = 0;
      repeat (tbl[i].ncyc) tick();
      check($sformatf("tbl%0d_en_count", i), n_en, tbl[i].x_en);
      check($sformatf("tbl%0d_load_count", i), n_ld, tbl[i].x_ld);
      check($sformatf("tbl%0d_mode", i), {31'd0, mode}, {31'd0, tbl[i].x_mode});
      check($sformatf("tbl%0d_data", i), {28'd0, data}, {28'd0, tbl[i].x_data});
    end

    // Bounce rejection: short high bursts, then a clean hold.
    en_times.delete();
    h = 0;
    while (h < 40) begin
      l = $urandom_range(1, 3);
      btn_up = 1; repeat (l) tick();
      h += l;
      l = $urandom_range(1, 3);
      btn_up = 0; repeat (l) tick();
      h += l;
    end
    btn_up = 1;
    base = cyc;
    repeat (19) tick();
    btn_up = 0;
    repeat (15) tick();
    check("bounce_pulse_count", en_times.size(), 1);
    if (en_times.size() > 0) check("bounce_latency", en_times[0] - base, 7);
    check("bounce_mode", {31'd0, mode}, 32'd1);

    // Auto-repeat on a held down button.
    en_times.delete();
    btn_down = 1;
    base = cyc;
    repeat (57) tick();
    btn_down = 0;
    repeat (20) tick();
    check("repeat_pulse_count", en_times.size(), 6);
    for (int i = 0; i < 6 && i < en_times.size(); i++)
      check($sformatf("repeat_offset%0d", i), en_times[i] - base, exp_off[i]);
    check("repeat_mode", {31'd0, mode}, 32'd0);

    // Asynchronous reset in the middle of a repeat with buttons held.
    btn_load = 1; sw_data = 4'hC; repeat (10) tick();
    btn_load = 0; repeat (12) tick();
    check("load_c_data", {28'd0, data}, 32'hC);
    btn_down = 1; repeat (40) tick();
    #2 reset = 1'b1;
    #1 check("async_reset", {25'd0, en, load, mode, data}, 32'h10);
    model_reset();
    btn_down = 0;
    repeat (3) tick();
    reset = 1'b0;
    en_times.delete();
    repeat (20) tick();
    check("post_reset_quiet", en_times.size(), 0);
    btn_up = 1; base = cyc;
    repeat (12) tick();
    btn_up = 0;
    repeat (15) tick();
    check("post_reset_press_count", en_times.size(), 1);
    if (en_times.size() > 0) check("post_reset_press_latency", en_times[0] - base, 7);

    // Random button activity against the model.
    pins = 3'b000;
    for (int b = 0; b < 3; b++) rem[b] = $urandom_range(1, 30);
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 3; b++) begin
        if (rem[b] == 0) begin
          pins[b] = ~pins[b];
          rem[b] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 60);
        end
        rem[b]--;
      end
      btn_up = pins[0]; btn_down = pins[1]; btn_load = pins[2];
      if (n % 16 == 0) sw_data = 4'($urandom);
      reset = ($urandom_range(0, 999) == 0);
      tick();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
